// File: rtl/alu_mc.sv
// Multi-cycle ALU: add/sub/logic/shift/rotate, compare and flag ops in one EXEC cycle;
// optional iterative shift-add multiply and restoring divide (macro ALU_MC_MULDIV_EN).
module alu_mc #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     op1,
    input  logic [WIDTH-1:0]     op2,
    input  logic [3:0]           opcode,
    input  logic [3:0]           funct_code,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 zero,
    output logic                 err
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    localparam logic [3:0] OPC_A   = 4'b0000;
    localparam logic [3:0] OPC_B   = 4'b1000;
    localparam logic [3:0] OPC_LT  = 4'b0100;
    localparam logic [3:0] OPC_GT  = 4'b0101;
    localparam logic [3:0] OPC_EQ  = 4'b0110;
    localparam logic [3:0] OPC_SET = 4'b1100;
    localparam logic [3:0] OPC_CLR = 4'b1111;

    localparam logic [3:0] F_ADD = 4'b1111;
    localparam logic [3:0] F_SUB = 4'b1110;
    localparam logic [3:0] F_AND = 4'b1101;
    localparam logic [3:0] F_OR  = 4'b1100;
    localparam logic [3:0] F_SHL = 4'b1010;
    localparam logic [3:0] F_SHR = 4'b1011;
    localparam logic [3:0] F_ROL = 4'b1000;
    localparam logic [3:0] F_ROR = 4'b1001;

    localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);
    localparam logic [SHW:0]     W_SH  = (SHW+1)'(WIDTH);

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_q, b_q;
    logic [3:0]       opc_q, fn_q;
    logic             accept;
    logic             exec_last;

    logic [2*WIDTH-1:0] res_c;
    logic               zero_c, err_c;
    logic [WIDTH:0]     sum_ab, dif_ab, sum_b4;
    logic [SHW:0]       rot_raw, rot_amt;
    logic [2*WIDTH-1:0] rol_t, ror_t;

    assign accept = in_valid && in_ready;

`ifdef ALU_MC_MULDIV_EN
    localparam logic [3:0] F_MUL = 4'b0001;
    localparam logic [3:0] F_DIV = 4'b0010;
    localparam int         CW    = $clog2(WIDTH);

    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc, acc_nxt;
    logic               is_iter, is_div, last_iter;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH+1:0]   div_trial;

    assign is_div    = (opc_q == OPC_A) && (fn_q == F_DIV);
    assign is_iter   = (opc_q == OPC_A) && ((fn_q == F_MUL) || is_div);
    assign last_iter = (cnt == CW'(WIDTH-1));
    assign exec_last = !is_iter || last_iter;

    // acc holds {partial product, multiplier} for mul and {remainder, dividend/quotient} for div
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_q} : '0);
        div_trial = {1'b0, acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {2'b00, b_q};
        if (is_div) begin
            if (!div_trial[WIDTH+1])
                acc_nxt = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                acc_nxt = {acc[2*WIDTH-2:0], 1'b0};
        end else begin
            acc_nxt = {mul_sum, acc[WIDTH-1:1]};
        end
    end
`else
    assign exec_last = 1'b1;
`endif

    // Single-cycle datapath, evaluated from the latched request while in EXEC
    always_comb begin
        sum_ab  = {1'b0, a_q} + {1'b0, b_q};
        dif_ab  = {1'b0, a_q} - {1'b0, b_q};
        sum_b4  = {1'b0, a_q} + {{(WIDTH-3){1'b0}}, b_q[3:0]};
        rot_raw = {1'b0, b_q[SHW-1:0]};
        rot_amt = (rot_raw >= W_SH) ? (rot_raw - W_SH) : rot_raw;
        rol_t   = {a_q, a_q} << rot_amt;
        ror_t   = {a_q, a_q} >> rot_amt;
        res_c   = '0;
        zero_c  = 1'b0;
        err_c   = 1'b0;
        case (opc_q)
            OPC_A: begin
                case (fn_q)
                    F_ADD:   res_c[WIDTH:0]   = sum_ab;
                    F_SUB:   res_c[WIDTH:0]   = dif_ab;
                    F_AND:   res_c[WIDTH-1:0] = a_q & b_q;
                    F_OR:    res_c[WIDTH-1:0] = a_q | b_q;
                    F_SHL:   res_c[WIDTH-1:0] = (b_q >= W_VAL) ? '0 : (a_q << b_q);
                    F_SHR:   res_c[WIDTH-1:0] = (b_q >= W_VAL) ? '0 : (a_q >> b_q);
                    F_ROL:   res_c[WIDTH-1:0] = rol_t[2*WIDTH-1:WIDTH];
                    F_ROR:   res_c[WIDTH-1:0] = ror_t[WIDTH-1:0];
                    default: err_c = 1'b1;
                endcase
            end
            OPC_B:   res_c[WIDTH:0] = sum_b4;
            OPC_LT:  zero_c = (a_q < b_q);
            OPC_GT:  zero_c = (a_q > b_q);
            OPC_EQ:  zero_c = (a_q == b_q);
            OPC_SET: zero_c = 1'b1;
            OPC_CLR: zero_c = 1'b0;
            default: err_c = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = EXEC;
            end
            EXEC: begin
                if (exec_last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            opc_q  <= '0;
            fn_q   <= '0;
            result <= '0;
            zero   <= 1'b0;
            err    <= 1'b0;
`ifdef ALU_MC_MULDIV_EN
            cnt    <= '0;
            acc    <= '0;
`endif
        end else begin
            if (accept) begin
                a_q   <= op1;
                b_q   <= op2;
                opc_q <= opcode;
                fn_q  <= funct_code;
`ifdef ALU_MC_MULDIV_EN
                cnt   <= '0;
                acc   <= ((opcode == OPC_A) && (funct_code == F_MUL)) ?
                         {{WIDTH{1'b0}}, op2} : {{WIDTH{1'b0}}, op1};
`endif
            end
            if (state == EXEC) begin
`ifdef ALU_MC_MULDIV_EN
                if (is_iter) begin
                    acc <= acc_nxt;
                    cnt <= cnt + 1'b1;
                    if (last_iter) begin
                        result <= acc_nxt;
                        zero   <= 1'b0;
                        err    <= is_div && (b_q == '0);
                    end
                end else begin
                    result <= res_c;
                    zero   <= zero_c;
                    err    <= err_c;
                end
`else
                result <= res_c;
                zero   <= zero_c;
                err    <= err_c;
`endif
            end
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed and randomized bench for alu_mc (WIDTH=8) against an arithmetic reference model.
module tb_alu_mc;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst, in_valid, in_ready, out_valid, out_ready, zero, err;
    logic [W-1:0]   op1, op2;
    logic [3:0]     opcode, funct_code;
    logic [2*W-1:0] result;

    int checks = 0;
    int errors = 0;

    alu_mc #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op1(op1), .op2(op2), .opcode(opcode), .funct_code(funct_code),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour from the operation definitions, using integer arithmetic
    task automatic model(input int a, input int b, input int opc, input int fn,
                         output int res, output int z, output int e, output int lat);
        int k;
        bit md;
`ifdef ALU_MC_MULDIV_EN
        md = 1'b1;
`else
        md = 1'b0;
`endif
        res = 0; z = 0; e = 0; lat = 2;
        k = b % W;
        if (opc == 0) begin
            case (fn)
                15: res = a + b;
                14: res = (a - b) & 'h1FF;
                13: res = a & b;
                12: res = a | b;
                10: res = (b >= W) ? 0 : ((a << b) & 'hFF);
                11: res = (b >= W) ? 0 : (a >> b);
                8:  res = ((a << k) | (a >> (W - k))) & 'hFF;
                9:  res = ((a >> k) | (a << (W - k))) & 'hFF;
                1:  if (md) begin res = a * b; lat = W + 1; end else e = 1;
                2:  if (md) begin
                        lat = W + 1;
                        if (b == 0) begin res = (a << W) | 'hFF; e = 1; end
                        else res = ((a % b) << W) | (a / b);
                    end else e = 1;
                default: e = 1;
            endcase
        end else begin
            case (opc)
                8:  res = a + (b & 15);
                4:  z = (a < b) ? 1 : 0;
                5:  z = (a > b) ? 1 : 0;
                6:  z = (a == b) ? 1 : 0;
                12: z = 1;
                15: z = 0;
                default: e = 1;
            endcase
        end
    endtask

    task automatic run_txn(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] opc, input logic [3:0] fn,
                           input int exp_res, input int exp_z, input int exp_e,
                           input int exp_lat, input int hold);
        int n;
        @(negedge clk);
        check({tag, ".in_ready"}, 32'(in_ready), 1);
        op1 = a; op2 = b; opcode = opc; funct_code = fn; in_valid = 1'b1;
        @(posedge clk);
        n = 1;
        @(negedge clk);
        in_valid = 1'b0;
        op1 = 8'($urandom); op2 = 8'($urandom);
        opcode = 4'($urandom); funct_code = 4'($urandom);
        while (!out_valid && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check({tag, ".latency"}, 32'(n), 32'(exp_lat));
        check({tag, ".result"}, 32'(result), 32'(exp_res));
        check({tag, ".zero"}, 32'(zero), 32'(exp_z));
        check({tag, ".err"}, 32'(err), 32'(exp_e));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check({tag, ".hold_out"}, {29'd0, out_valid, zero, err},
                  {29'd0, 1'b1, 1'(exp_z), 1'(exp_e)});
            check({tag, ".hold_res"}, 32'(result), 32'(exp_res));
            check({tag, ".hold_in_ready"}, 32'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ".drained"}, {30'd0, out_valid, in_ready}, 32'b01);
    endtask

    initial begin
        int r, z, e, lat, stale, sel;
        logic [7:0] a, b;
        logic [3:0] opc, fn;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op1 = '0; op2 = '0; opcode = '0; funct_code = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.out_valid", 32'(out_valid), 0);
        check("reset.result", 32'(result), 0);
        check("reset.flags", {30'd0, zero, err}, 0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("reset.in_ready_after", 32'(in_ready), 1);

        run_txn("add_f0_20", 8'hF0, 8'h20, 4'b0000, 4'b1111, 'h0110, 0, 0, 2, 0);
`ifdef ALU_MC_MULDIV_EN
        run_txn("mul_0f_0f", 8'h0F, 8'h0F, 4'b0000, 4'b0001, 'h00E1, 0, 0, W + 1, 1);
        run_txn("div_200_7", 8'd200, 8'd7, 4'b0000, 4'b0010, 'h041C, 0, 0, W + 1, 0);
        run_txn("div_by_0", 8'h37, 8'h00, 4'b0000, 4'b0010, 'h37FF, 0, 1, W + 1, 2);
`else
        run_txn("mul_disabled", 8'h0F, 8'h0F, 4'b0000, 4'b0001, 0, 0, 1, 2, 0);
        run_txn("div_disabled", 8'h37, 8'h00, 4'b0000, 4'b0010, 0, 0, 1, 2, 1);
`endif
        run_txn("rotl_81_9", 8'h81, 8'h09, 4'b0000, 4'b1000, 'h0003, 0, 0, 2, 0);

        // Reset during the 4th cycle of a multiply, with a nonzero result still registered
        @(negedge clk);
        op1 = 8'h0F; op2 = 8'h0F; opcode = 4'b0000; funct_code = 4'b0001; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid.out_valid", 32'(out_valid), 0);
        check("rst_mid.result", 32'(result), 0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid.in_ready", 32'(in_ready), 1);
        stale = 0;
        repeat (12) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("rst_mid.no_stale", 32'(stale), 0);

        // Reset coinciding with a valid request must win
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1;
        op1 = 8'h01; op2 = 8'h02; opcode = 4'b0000; funct_code = 4'b1111;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        check("rst_accept.in_ready", 32'(in_ready), 1);
        stale = 0;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("rst_accept.no_result", 32'(stale), 0);

        run_txn("lt_5_9_hold", 8'h05, 8'h09, 4'b0100, 4'b0000, 0, 1, 0, 2, 5);
        run_txn("gt_false", 8'h05, 8'h09, 4'b0101, 4'b0000, 0, 0, 0, 2, 0);
        run_txn("eq_true", 8'h5A, 8'h5A, 4'b0110, 4'b0000, 0, 1, 0, 2, 0);
        run_txn("shl_by_8", 8'hFF, 8'h08, 4'b0000, 4'b1010, 0, 0, 0, 2, 0);
        run_txn("shr_80_7", 8'h80, 8'h07, 4'b0000, 4'b1011, 'h0001, 0, 0, 2, 0);
        run_txn("sub_borrow", 8'h10, 8'h20, 4'b0000, 4'b1110, 'h01F0, 0, 0, 2, 0);
        run_txn("typeb_carry", 8'hFF, 8'hAF, 4'b1000, 4'b0000, 'h010E, 0, 0, 2, 0);
        run_txn("rotr_01_1", 8'h01, 8'h01, 4'b0000, 4'b1001, 'h0080, 0, 0, 2, 0);
        run_txn("typed_set", 8'h00, 8'h00, 4'b1100, 4'b0000, 0, 1, 0, 2, 0);
        run_txn("typed_clr", 8'hFF, 8'hFF, 4'b1111, 4'b0000, 0, 0, 0, 2, 0);
        run_txn("bad_opcode", 8'h12, 8'h34, 4'b0011, 4'b1111, 0, 0, 1, 2, 0);
        run_txn("bad_funct", 8'h12, 8'h34, 4'b0000, 4'b0000, 0, 0, 1, 2, 0);

        repeat (150) begin
            a   = 8'($urandom);
            sel = $urandom_range(0, 3);
            b   = (sel == 0) ? 8'h00 : (sel == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom);
            opc = ($urandom_range(0, 1) == 1) ? 4'b0000 : 4'($urandom_range(0, 15));
            fn  = 4'($urandom);
            model(int'(a), int'(b), int'(opc), int'(fn), r, z, e, lat);
            run_txn("random", a, b, opc, fn, r, z, e, lat, $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal values 4..32.
REQ-002 Parameter SHW, default $clog2(WIDTH), number of op2 low bits used as the shift or rotate amount.
REQ-003 clk  input  1  rising-edge clock; the block has this one clock only.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  the request fields are valid this cycle.
REQ-006 in_ready  output  1  the block can accept a request this cycle.
REQ-007 op1, op2  input  WIDTH each  operands.
REQ-008 opcode  input  4  instruction class and operation.
REQ-009 funct_code  input  4  Type A sub-operation.
REQ-010 out_valid  output  1  result, zero and err are valid.
REQ-011 out_ready  input  1  the consumer accepts the result.
REQ-012 result  output  2*WIDTH  operation result.
REQ-013 zero  output  1  branch/compare flag.
REQ-014 err  output  1  the operation was illegal or was a divide by zero.

Function
REQ-015 The FSM SHALL have the states IDLE, EXEC and DONE; in_ready SHALL be 1 only in IDLE.
REQ-016 A request SHALL be accepted when in_valid=1 and in_ready=1: operands and codes are latched and the FSM moves IDLE->EXEC.
REQ-017 Single-cycle operations SHALL complete in EXEC (EXEC->DONE), so out_valid rises 2 cycles after the accept edge.
REQ-018 Multiply and divide SHALL iterate for WIDTH cycles in EXEC using an internal counter, so out_valid rises WIDTH+1 cycles after the accept edge.
REQ-019 In DONE, result, zero and err SHALL stay stable while out_valid=1 and out_ready=0.
REQ-020 When out_ready=1 in DONE, the FSM SHALL move to IDLE; in_valid is ignored outside IDLE and there is no bypass.
REQ-021 Type A (opcode 0000) funct_code decode SHALL be: 1111 add, 1110 sub, 1101 and, 1100 or, 1010 shl, 1011 shr, 1000 rotl, 1001 rotr, 0001 mul, 0010 div.
REQ-022 For add and sub, result[WIDTH-1:0] SHALL be the modulo-2^WIDTH value, result[WIDTH] SHALL be the carry (add) or borrow (sub), and the upper bits SHALL be 0.
REQ-023 For and, or, shl and shr, result[WIDTH-1:0] SHALL hold the value and the upper bits SHALL be 0.
REQ-024 Shifts SHALL be logical; an op2 value of WIDTH or more SHALL give 0.
REQ-025 Rotates SHALL rotate op1 by op2[SHW-1:0], i.e. by op2 modulo WIDTH, and complete in one cycle.
REQ-026 Mul SHALL be unsigned shift-add producing the full 2*WIDTH-bit product.
REQ-027 Div SHALL be unsigned restoring division: result = {remainder, quotient}.
REQ-028 Divide by zero SHALL give quotient = all ones, remainder = op1 and err=1, with the same latency as a normal divide.
REQ-029 Type B opcode 1000 SHALL compute op1 + zero-extended op2[3:0], with carry in result[WIDTH].
REQ-030 Type C SHALL compare unsigned with result=0: opcode 0100 sets zero=(op1<op2), 0101 sets zero=(op1>op2), 0110 sets zero=(op1==op2).
REQ-031 Type D opcode 1100 SHALL set zero=1 and opcode 1111 SHALL set zero=0, with result=0 in both cases.
REQ-032 zero SHALL be 0 for all Type A and Type B operations.
REQ-033 Any undefined opcode or funct_code SHALL give result=0, zero=0, err=1 with single-cycle latency.

Reset
REQ-034 When rst=1 at a clock edge, the FSM SHALL go to IDLE and out_valid, result, zero, err and the iteration counter SHALL all clear to 0.
REQ-035 rst SHALL override any simultaneous accept.
REQ-036 Reset mid-operation (in EXEC or DONE) SHALL abort the operation, produce no out_valid and discard the result.
REQ-037 in_ready SHALL be 1 in the cycle after reset is released.

Configuration
REQ-038 With macro ALU_MC_MULDIV_EN defined, mul and div SHALL be built as specified in REQ-018, REQ-026, REQ-027 and REQ-028.
REQ-039 Without ALU_MC_MULDIV_EN, funct_codes 0001 and 0010 SHALL be treated as illegal (REQ-033), no iteration datapath SHALL be built, and every operation SHALL be single-cycle.

Verification (WIDTH=8)
REQ-040 add 0xF0+0x20 -> result=0x0110, zero=0, err=0, out_valid 2 cycles after accept.
REQ-041 mul 0x0F*0x0F -> result=0x00E1 at accept+9 cycles; then div 200/7 -> result=0x041C at accept+9 cycles.
REQ-042 div 0x37/0x00 -> result=0x37FF, err=1; rotl 0x81 by op2=0x09 -> result=0x0003.
REQ-043 opcode 0100 with op1=0x05, op2=0x09 -> zero=1, result=0; with out_ready held at 0 for 5 cycles, all outputs stay stable and in_ready stays 0.
REQ-044 rst=1 during the 4th cycle of a mul -> next cycle out_valid=0 and result=0; in_ready=1 one cycle after rst falls; no stale result is ever delivered.
REQ-045 Build without ALU_MC_MULDIV_EN and issue funct_code 0001 -> err=1, result=0 at accept+2 cycles.
